// File: rtl/digtal_frame_sched.sv
// Receive-buffer controller for the digital interface.
// Incoming bytes are written into a circular 2^ADDR_W-byte RAM. Each CS
// falling edge requests one output byte. Each frame is INS_LEN sync-header
// bytes followed by PAYLOAD_LEN payload bytes popped from the buffer.
// FILL_BYTE is sent in a payload slot when the buffer is empty.
module digtal_frame_sched #(
  parameter int          ADDR_W      = 11,
  parameter int          INS_LEN     = 4,
  parameter logic [63:0] SYNC_WORDS  = 64'hEB9090EBEB9090EB,
  parameter int          PAYLOAD_LEN = 252,
  parameter logic [7:0]  FILL_BYTE   = 8'h55
) (
  input  logic              Clock,
  input  logic              Rst_n,
  input  logic              Wr_Strobe,
  input  logic [7:0]        Wr_Data,
  input  logic              CS,
  output logic [7:0]        RAM_Data_In,
  output logic [ADDR_W-1:0] RAM_WRADD,
  output logic              RAM_WREN,
  output logic [ADDR_W-1:0] RAM_RDADD,
  output logic              RAM_RDEN,
  input  logic [7:0]        RAM_Q,
  output logic [7:0]        Out_Data,
  output logic              Out_Valid,
  output logic [ADDR_W:0]   Level,
  output logic              Ovf_Flag,
  output logic              Udf_Flag,
  output logic              Req_Err
);

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [16:0]     HDR_N    = 17'(INS_LEN);
  localparam logic [16:0]     CNT_LAST = 17'(INS_LEN + PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, EMIT} state_t;
  typedef enum logic [1:0] {SRC_HDR, SRC_RAM, SRC_FILL} src_t;

  state_t            state;
  src_t              src;
  logic              cs_s1, cs_s2, cs_d;
  logic              req, wr_ok, pop;
  logic [16:0]       cnt;
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   lvl;
  logic [7:0]        hdr_byte, hdr_next;

  // A request is a 1->0 transition of the synchronised chip select
  assign req   = cs_d & ~cs_s2;
  // Fullness uses the registered level, so a same-cycle pop never frees room
  assign wr_ok = Wr_Strobe && (lvl < DEPTH);
  assign pop   = (state == ISSUE) && (cnt >= HDR_N) && (lvl != '0);

  assign RAM_WREN    = wr_ok;
  assign RAM_WRADD   = wptr;
  assign RAM_Data_In = wr_ok ? Wr_Data : 8'h00;
  assign RAM_RDEN    = pop;
  assign RAM_RDADD   = rptr;
  assign Level       = lvl;

  // Select header byte [cnt], MSB-first within SYNC_WORDS
  always_comb begin
    hdr_next = 8'h00;
    for (int k = 0; k < 8; k++)
      if (cnt[2:0] == 3'(k)) hdr_next = SYNC_WORDS[63-8*k -: 8];
  end

  // Two-flop synchroniser plus delay stage for edge detection on CS
  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      cs_s1 <= 1'b1;
      cs_s2 <= 1'b1;
      cs_d  <= 1'b1;
    end else begin
      cs_s1 <= CS;
      cs_s2 <= cs_s1;
      cs_d  <= cs_s2;
    end
  end

  // Buffer pointers, occupancy and overflow tracking
  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      lvl      <= '0;
      Ovf_Flag <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (Wr_Strobe && !wr_ok) Ovf_Flag <= 1'b1;
      case ({wr_ok, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // Request FSM: choose the byte source in ISSUE, present it in EMIT
  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      src       <= SRC_HDR;
      cnt       <= '0;
      hdr_byte  <= 8'h00;
      Out_Data  <= 8'h00;
      Out_Valid <= 1'b0;
      Udf_Flag  <= 1'b0;
      Req_Err   <= 1'b0;
    end else begin
      Out_Valid <= 1'b0;
      if (req && state != IDLE) Req_Err <= 1'b1;
      case (state)
        IDLE: if (req) state <= ISSUE;
        ISSUE: begin
          state <= EMIT;
          if (cnt < HDR_N) begin
            src      <= SRC_HDR;
            hdr_byte <= hdr_next;
          end else if (lvl != '0) begin
            src <= SRC_RAM;
          end else begin
            src      <= SRC_FILL;
            Udf_Flag <= 1'b1;
          end
        end
        EMIT: begin
          state     <= IDLE;
          Out_Valid <= 1'b1;
          case (src)
            SRC_HDR: Out_Data <= hdr_byte;
            SRC_RAM: Out_Data <= RAM_Q;
            default: Out_Data <= FILL_BYTE;
          endcase
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digtal_frame_sched.sv
// Directed bench for digtal_frame_sched with a behavioural dual-port RAM.
`timescale 1ns/1ps
module tb_digtal_frame_sched;

  logic        Clock = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Wr_Strobe = 1'b0;
  logic [7:0]  Wr_Data = 8'h00;
  logic        CS = 1'b1;
  logic [7:0]  RAM_Data_In;
  logic [10:0] RAM_WRADD;
  logic        RAM_WREN;
  logic [10:0] RAM_RDADD;
  logic        RAM_RDEN;
  logic [7:0]  RAM_Q = 8'h00;
  logic [7:0]  Out_Data;
  logic        Out_Valid;
  logic [11:0] Level;
  logic        Ovf_Flag, Udf_Flag, Req_Err;

  digtal_frame_sched dut (
    .Clock(Clock), .Rst_n(Rst_n), .Wr_Strobe(Wr_Strobe), .Wr_Data(Wr_Data),
    .CS(CS), .RAM_Data_In(RAM_Data_In), .RAM_WRADD(RAM_WRADD),
    .RAM_WREN(RAM_WREN), .RAM_RDADD(RAM_RDADD), .RAM_RDEN(RAM_RDEN),
    .RAM_Q(RAM_Q), .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Level(Level),
    .Ovf_Flag(Ovf_Flag), .Udf_Flag(Udf_Flag), .Req_Err(Req_Err)
  );

  always #17 Clock = ~Clock;

  // Buffer RAM: one-cycle registered read
  logic [7:0] mem [0:2047];
  always @(posedge Clock) begin
    if (RAM_WREN) mem[RAM_WRADD] <= RAM_Data_In;
    if (RAM_RDEN) RAM_Q <= mem[RAM_RDADD];
  end

  int n_cmp = 0;
  int n_err = 0;
  int pos = 0;
  logic [7:0] q [$];
  logic [7:0] hdr [4] = '{8'hEB, 8'h90, 8'h90, 8'hEB};
  logic        last_wren;
  logic [10:0] last_wradd;
  logic [7:0]  last_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; CS = 1'b1; Wr_Strobe = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Rst_n = 1'b1;
    q.delete();
    pos = 0;
    @(negedge Clock);
  endtask

  // One request: fall CS, expect Out_Valid after the 5th rising edge
  task automatic do_req(output logic [7:0] d);
    int n;
    n = 0;
    CS = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clock);
      if (Out_Valid) begin n = i; break; end
    end
    chk("req_latency", 32'(n), 32'd5);
    d = Out_Data;
    CS = 1'b1;
    @(negedge Clock);
    chk("valid_pulse", 32'(Out_Valid), 32'd0);
    repeat (2) @(negedge Clock);
  endtask

  task automatic model_req(input string tag);
    logic [7:0] e, d;
    if (pos < 4) e = hdr[pos];
    else if (q.size() > 0) e = q.pop_front();
    else e = 8'h55;
    do_req(d);
    chk(tag, 32'(d), 32'(e));
    pos = (pos + 1) % 256;
  endtask

  task automatic wr(input logic [7:0] b);
    Wr_Strobe = 1'b1; Wr_Data = b;
    #1;
    last_wren = RAM_WREN; last_wradd = RAM_WRADD; last_wdata = RAM_Data_In;
    if (q.size() < 2048) q.push_back(b);
    @(negedge Clock);
    Wr_Strobe = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int pulses;

    // Reset state
    #5;
    chk("rst_out_data", 32'(Out_Data), 32'h0);
    chk("rst_out_valid", 32'(Out_Valid), 32'h0);
    chk("rst_level", 32'(Level), 32'h0);
    chk("rst_flags", 32'({Ovf_Flag, Udf_Flag, Req_Err}), 32'h0);
    chk("rst_ram_en", 32'({RAM_WREN, RAM_RDEN}), 32'h0);
    chk("rst_ram_addr", 32'({RAM_WRADD, RAM_RDADD}), 32'h0);
    do_reset();

    // Header with an empty buffer, then underflow fill
    do_req(d); chk("hdr0", 32'(d), 32'hEB);
    do_req(d); chk("hdr1", 32'(d), 32'h90);
    do_req(d); chk("hdr2", 32'(d), 32'h90);
    do_req(d); chk("hdr3", 32'(d), 32'hEB);
    chk("udf_before", 32'(Udf_Flag), 32'h0);
    do_req(d); chk("fill", 32'(d), 32'h55);
    chk("udf_after", 32'(Udf_Flag), 32'h1);

    // Five bytes then one complete 256-byte frame
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr(8'(i));
      chk("wr_en", 32'(last_wren), 32'h1);
      chk("wr_addr", 32'(last_wradd), 32'(i - 1));
      chk("wr_data", 32'(last_wdata), 32'(i));
    end
    chk("lvl5", 32'(Level), 32'd5);
    for (int i = 0; i < 256; i++) model_req("frame_byte");
    chk("frame_lvl0", 32'(Level), 32'd0);
    do_req(d); chk("frame2_hdr0", 32'(d), 32'hEB);

    // Fill past capacity: last byte dropped, then drain in order
    do_reset();
    for (int i = 0; i < 2048; i++) wr(8'(i));
    chk("full_ovf_before", 32'(Ovf_Flag), 32'h0);
    chk("full_lvl", 32'(Level), 32'd2048);
    wr(8'h00);
    chk("full_drop_wren", 32'(last_wren), 32'h0);
    chk("full_lvl_held", 32'(Level), 32'd2048);
    chk("full_ovf", 32'(Ovf_Flag), 32'h1);
    while (q.size() > 0) model_req("drain_byte");
    chk("drain_lvl0", 32'(Level), 32'd0);

    // Pointer wrap
    do_reset();
    for (int i = 0; i < 2040; i++) wr(8'(i));
    while (q.size() > 0) model_req("wrap_pre");
    for (int i = 0; i < 20; i++) begin
      wr(8'(8'hA0 + i));
      chk("wrap_wradd", 32'(last_wradd), 32'((2040 + i) % 2048));
    end
    chk("wrap_lvl", 32'(Level), 32'd20);
    while (q.size() > 0) model_req("wrap_byte");
    chk("wrap_lvl0", 32'(Level), 32'd0);

    // Write coinciding with ISSUE of an empty payload slot
    do_reset();
    for (int i = 0; i < 4; i++) model_req("coll_hdr");
    CS = 1'b0;
    repeat (3) @(negedge Clock);
    chk("coll_lvl_a", 32'(Level), 32'd0);
    Wr_Strobe = 1'b1; Wr_Data = 8'hAA;
    @(negedge Clock);
    Wr_Strobe = 1'b0;
    chk("coll_lvl_b", 32'(Level), 32'd1);
    @(negedge Clock);
    chk("coll_valid", 32'(Out_Valid), 32'h1);
    chk("coll_fill", 32'(Out_Data), 32'h55);
    CS = 1'b1;
    repeat (3) @(negedge Clock);
    q.push_back(8'hAA);
    pos = 5;
    model_req("coll_pop");
    chk("coll_lvl_c", 32'(Level), 32'd0);

    // Second request edge while the first is in service
    do_reset();
    CS = 1'b0;
    @(negedge Clock); CS = 1'b1;
    @(negedge Clock); CS = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (Out_Valid) pulses++;
    end
    CS = 1'b1;
    repeat (3) @(negedge Clock);
    chk("dbl_pulses", 32'(pulses), 32'd1);
    chk("dbl_data", 32'(Out_Data), 32'hEB);
    chk("dbl_req_err", 32'(Req_Err), 32'h1);
    pos = 1;
    model_req("dbl_next");

    // Reset asserted while in EMIT
    CS = 1'b0;
    repeat (4) @(negedge Clock);
    Rst_n = 1'b0; CS = 1'b1;
    #1;
    chk("emit_rst_data", 32'(Out_Data), 32'h0);
    chk("emit_rst_valid", 32'(Out_Valid), 32'h0);
    chk("emit_rst_err", 32'(Req_Err), 32'h0);
    @(negedge Clock);
    Rst_n = 1'b1;
    q.delete();
    pos = 0;
    pulses = 0;
    repeat (4) begin
      @(negedge Clock);
      if (Out_Valid) pulses++;
    end
    chk("emit_rst_no_pulse", 32'(pulses), 32'd0);
    model_req("emit_rst_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digtal_frame_sched.md
Name: digtal_frame_sched

Overview:
Controller for the 2048-byte receive buffer of the digital interface. It manages the buffer as a circular FIFO: it writes received bytes at the write pointer and, on each falling edge of the external chip select, reads the next byte out. Each outgoing frame starts with the configurable sync header, followed by payload bytes read from the buffer. It sits between the UART receiver (byte strobe and data), the dual-port buffer RAM and the digital output pins, and reports overflow, underflow and request-collision status.

Parameters:
ADDR_W, 11, buffer address width; depth = 2^ADDR_W = 2048 bytes
INS_LEN, 4, sync header length in bytes; legal range 4..8
SYNC_WORDS, 64'hEB9090EBEB9090EB, header bytes, MSB first; header byte k = SYNC_WORDS[63-8k -: 8]
PAYLOAD_LEN, 252, buffer bytes per frame; legal range 1..65535
FILL_BYTE, 8'h55, byte emitted in a payload slot when the buffer is empty

Ports:
Clock  in  1  single system clock, 29.4912 MHz; all logic on rising edge
Rst_n  in  1  asynchronous, active-low reset
Wr_Strobe  in  1  one-cycle pulse in Clock domain: Wr_Data is a valid received byte
Wr_Data  in  8  received byte
CS  in  1  external chip select, asynchronous to Clock; a falling edge is one byte request
RAM_Data_In  out  8  RAM write data
RAM_WRADD  out  ADDR_W  RAM write address
RAM_WREN  out  1  RAM write enable
RAM_RDADD  out  ADDR_W  RAM read address
RAM_RDEN  out  1  RAM read enable
RAM_Q  in  8  RAM read data; valid 1 cycle after RAM_RDEN
Out_Data  out  8  byte presented to the digital output pins; held until the next byte is presented
Out_Valid  out  1  one-cycle pulse when Out_Data updates
Level  out  ADDR_W+1  buffer occupancy, 0..2048
Ovf_Flag  out  1  sticky: a byte was dropped because the buffer was full
Udf_Flag  out  1  sticky: FILL_BYTE was emitted in a payload slot
Req_Err  out  1  sticky: a request edge arrived while a request was still in service

Behaviour:
- Reset (Rst_n=0, asynchronous): all outputs 0, including Out_Data. Write and read pointers = 0; Level = 0; byte counter = 0; state = IDLE. A reset asserted in any state aborts that state immediately. After release, the next frame starts at header byte 0. CS synchronisers reset to 1.
- Write path: Wr_Strobe is accepted when Level < 2^ADDR_W. In the same cycle RAM_WREN=1, RAM_WRADD=wptr and RAM_Data_In=Wr_Data are driven combinationally from the registered wptr. wptr increments mod 2^ADDR_W, so it wraps from 2047 to 0. If Level = 2^ADDR_W, the byte is dropped, RAM_WREN stays 0 and Ovf_Flag is set. A pop in the same cycle does not rescue the byte; fullness is judged on the registered Level.
- CS handling: CS passes through a 2-flop synchroniser plus a delay register. A request is detected in cycle E when the delayed value is 1 and the synchronised value is 0.
- State machine: IDLE -> ISSUE -> EMIT -> IDLE.
  - IDLE: on a request at E, go to ISSUE.
  - ISSUE (cycle E+1): if byte counter < INS_LEN, latch header byte [counter]. Otherwise, if Level > 0, assert RAM_RDEN with RAM_RDADD = rptr and pop: rptr increments mod 2^ADDR_W. Otherwise select FILL_BYTE and set Udf_Flag.
  - EMIT (cycle E+2): load Out_Data from the header byte, RAM_Q or FILL_BYTE; pulse Out_Valid. The byte counter increments and wraps to 0 after INS_LEN+PAYLOAD_LEN-1.
- Latency: Out_Data and Out_Valid are visible after the rising edge ending cycle E+2, for every byte type. This is 2 cycles after detection and 4-5 cycles after the CS pin edge.
- A request detected while the state is ISSUE or EMIT is ignored and sets Req_Err. The byte counter does not advance.
- Level update: +1 on an accepted write, -1 on a pop, unchanged when both occur in the same cycle.
- A write and an ISSUE in the same cycle with Level = 0: the slot is an underflow and emits FILL_BYTE. The written byte is popped by a later request.
- Sticky flags are cleared only by reset.

Test Plan:
- Reset, then 4 CS falling edges with no writes -> Out_Data = EB, 90, 90, EB, each with an Out_Valid pulse 2 cycles after detection. Next edge -> 55 and Udf_Flag = 1.
- Write 01..05, then one full frame (256 requests) -> header, then 01..05, then 247 x 55. Level returns to 0. Second frame starts with EB.
- Write 2049 bytes 00..FF repeating with no reads -> Level = 2048 and Ovf_Flag = 1. Last write has RAM_WREN = 0. Reading out yields 00..FF x8 in order.
- Pointer wrap: write 2040 bytes, read 2040, then write 20 -> RAM_WRADD runs 2040..2047, 0..11. Payload reads return the 20 bytes in order across the wrap.
- Level = 0, Wr_Strobe of AA in the same cycle as ISSUE in a payload slot -> emits 55. Next request emits AA. Level goes 0, 1, 0.
- Two CS falling edges 1 cycle apart after synchronisation -> one Out_Valid pulse, Req_Err = 1, byte counter advances by 1. Rst_n pulsed during EMIT -> Out_Valid = 0, outputs 0, next byte is EB.
